mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single memory port between cpu_65c02 and one DMA requester (block-transfer/VDC DMA engine). Sits between CPU and memory: muxes address/data/strobes and drives the CPU RDY input to stall the core while DMA owns the bus. Handoff happens only on CPU read or idle cycles, so no CPU write is ever lost. A fairness counter bounds DMA bursts.

Parameters:
MAX_BURST, 16, max consecutive DMA-owned cycles before the bus is forcibly returned to the CPU (1..255)
MIN_CPU, 2, minimum CPU-owned cycles after any DMA tenure before a new handoff is allowed (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cpu_ab  in  16  CPU address
cpu_do  in  8  CPU write data
cpu_re  in  1  CPU read strobe
cpu_we  in  1  CPU write strobe
cpu_di  out  8  read data to CPU
cpu_rdy  out  1  CPU RDY; low stalls the core
dma_req  in  1  DMA bus request (level; held for the whole transfer)
dma_addr  in  16  DMA address
dma_wdata  in  8  DMA write data
dma_re  in  1  DMA read strobe
dma_we  in  1  DMA write strobe
dma_gnt  out  1  DMA owns bus this cycle
dma_rdata  out  8  DMA read data
dma_rvalid  out  1  dma_rdata valid
mem_addr  out  16  memory address
mem_din  out  8  memory write data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_dout  in  8  memory read data, valid 1 cycle after mem_re

Behaviour:
- Reset values: state CPU_OWN, cpu_rdy=1, dma_gnt=0, dma_rvalid=0, burst count 0, cpu-guard count 0, cpu_di hold register 0x00.
- States: CPU_OWN, HANDOFF, DMA_OWN, RETURN. cpu_rdy and dma_gnt are registered state decodes.
- CPU_OWN: mem_* = cpu_* (passthrough, combinational); cpu_rdy=1; cpu_di = mem_dout. The guard counter increments (saturating) each cycle. Go to HANDOFF when dma_req=1, cpu_we=0, and guard count >= MIN_CPU.
- HANDOFF (1 cycle): cpu_rdy=0; mem_re=mem_we=0; cpu_di = hold register, loaded with mem_dout at the end of this cycle (captures a read issued in the last CPU_OWN cycle). Next: DMA_OWN. If dma_req has dropped, go to RETURN instead.
- DMA_OWN: dma_gnt=1; mem_addr=dma_addr; mem_din=dma_wdata; mem_we=dma_we; mem_re=dma_re & ~dma_we (dma_we wins if both are set). Burst count increments every DMA_OWN cycle. Go to RETURN when dma_req=0, or when burst count reaches MAX_BURST (count==MAX_BURST-1 in the current cycle makes this the last granted cycle).
- RETURN (1 cycle): dma_gnt=0; mem idle; cpu_rdy=1 from the next cycle. Clear burst and guard counts. Next: CPU_OWN. The CPU re-issues its stalled read (65C02 RDY semantics); the arbiter does not replay it.
- While cpu_rdy=0, cpu_di is the hold register (stable).
- dma_rdata = mem_dout (combinational). dma_rvalid is registered: 1 in the cycle after a DMA_OWN cycle with mem_re=1. It can therefore be 1 during RETURN.
- Throttling: when dma_req is still high at the MAX_BURST exit, the DMA sees dma_gnt fall and must stall. Re-handoff occurs once MIN_CPU CPU cycles have elapsed and the CPU is not writing.
- CPU writing continuously: no handoff; the request stays pending indefinitely. This is intended, since 65C02 write runs are short.
- Reset mid-DMA: immediate return to reset values. dma_gnt falls asynchronously; the bus goes to CPU passthrough.

Test Plan:
- Idle DMA: CPU reads 0x1234 (mem holds 0xA5) -> mem_addr=0x1234, cpu_di=0xA5 next cycle; cpu_rdy stays 1, dma_gnt stays 0.
- Basic handoff: dma_req rises during a CPU read -> cpu_rdy=0 next cycle; dma_gnt=1 one cycle later; DMA writes 0x55 to 0x2000 -> mem_we=1, mem_addr=0x2000. Drop dma_req -> RETURN, then cpu_rdy=1, and the CPU read of 0x1234 returns the correct data.
- Write protection: dma_req asserted while cpu_we=1 for 3 cycles -> no handoff until the first cycle with cpu_we=0; all 3 CPU writes land in memory.
- Fairness: dma_req held high with 40 DMA reads, MAX_BURST=16, MIN_CPU=2 -> exactly 16 dma_gnt cycles, then RETURN, then >=2 cycles with cpu_rdy=1, then a new grant. Total of 40 dma_rvalid pulses, each carrying the correct data.
- DMA read latency: DMA reads 0x3000 (holds 0x7E) on its final granted cycle -> dma_rvalid=1 with dma_rdata=0x7E during RETURN.
- Reset mid-burst: assert reset on the 5th DMA cycle -> dma_gnt=0 and cpu_rdy=1 immediately (asynchronously). After release, state is CPU_OWN and a CPU fetch from 0xbeef proceeds.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one memory port between the 65C02 core and a DMA requester
module mem_bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int MIN_CPU   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_re,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_re,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);

    typedef enum logic [1:0] {
        CPU_OWN,
        HANDOFF,
        DMA_OWN,
        RETURN
    } state_t;

    localparam logic [3:0] GUARD_MIN  = 4'(MIN_CPU);
    localparam logic [3:0] GUARD_SAT  = 4'hF;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t      state;
    logic [7:0]  burst_cnt;
    logic [3:0]  guard_cnt;
    logic [7:0]  hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CPU_OWN;
            cpu_rdy    <= 1'b1;
            dma_gnt    <= 1'b0;
            dma_rvalid <= 1'b0;
            burst_cnt  <= 8'd0;
            guard_cnt  <= 4'd0;
            hold       <= 8'h00;
        end else begin
            dma_rvalid <= (state == DMA_OWN) && dma_re && !dma_we;
            case (state)
                CPU_OWN: begin
                    if (guard_cnt != GUARD_SAT)
                        guard_cnt <= guard_cnt + 4'd1;
                    // Never hand off during a CPU write: a stalled 65C02 write would be lost.
                    if (dma_req && !cpu_we && guard_cnt >= GUARD_MIN) begin
                        state   <= HANDOFF;
                        cpu_rdy <= 1'b0;
                    end
                end
                HANDOFF: begin
                    hold <= mem_dout;
                    if (dma_req) begin
                        state   <= DMA_OWN;
                        dma_gnt <= 1'b1;
                    end else begin
                        state <= RETURN;
                    end
                end
                DMA_OWN: begin
                    burst_cnt <= burst_cnt + 8'd1;
                    if (!dma_req || burst_cnt == BURST_LAST) begin
                        state   <= RETURN;
                        dma_gnt <= 1'b0;
                    end
                end
                RETURN: begin
                    burst_cnt <= 8'd0;
                    guard_cnt <= 4'd0;
                    state     <= CPU_OWN;
                    cpu_rdy   <= 1'b1;
                end
                default: begin
                    state   <= CPU_OWN;
                    cpu_rdy <= 1'b1;
                    dma_gnt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr = cpu_ab;
        mem_din  = cpu_do;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        cpu_di   = hold;
        case (state)
            CPU_OWN: begin
                mem_re = cpu_re;
                mem_we = cpu_we;
                cpu_di = mem_dout;
            end
            DMA_OWN: begin
                mem_addr = dma_addr;
                mem_din  = dma_wdata;
                mem_we   = dma_we;
                mem_re   = dma_re & ~dma_we;
            end
            default: begin
            end
        endcase
    end

    assign dma_rdata = mem_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter with memory and ownership model
module tb_mem_bus_arbiter;

    localparam int MAX_BURST = 16;
    localparam int MIN_CPU   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_ab = '0;
    logic [7:0]  cpu_do = '0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_re = 1'b0;
    logic        dma_we = 1'b0;
    logic        dma_gnt;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_dout = '0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(.MAX_BURST(MAX_BURST), .MIN_CPU(MIN_CPU)) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_re(dma_re), .dma_we(dma_we), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_re(mem_re), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one-cycle read latency.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        if (mem_re) mem_dout <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 13 + 5) & 255);
    endfunction

    // Ownership model: who holds the bus, how long they have held it.
    localparam int OWNER_CPU = 0, STALL_IN = 1, OWNER_DMA = 2, STALL_OUT = 3;
    int         m_owner = OWNER_CPU;
    int         m_cpu_cycles = 0;
    int         m_dma_cycles = 0;
    logic [7:0] m_latched = 8'h00;
    logic       m_rvalid = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = OWNER_CPU;
            m_cpu_cycles = 0;
            m_dma_cycles = 0;
            m_latched = 8'h00;
            m_rvalid = 1'b0;
        end else begin
            m_rvalid = (m_owner == OWNER_DMA) && dma_re && !dma_we;
            if (m_owner == OWNER_CPU) begin
                if (dma_req && !cpu_we && m_cpu_cycles >= MIN_CPU) m_owner = STALL_IN;
                m_cpu_cycles = (m_cpu_cycles < 15) ? m_cpu_cycles + 1 : 15;
            end else if (m_owner == STALL_IN) begin
                m_latched = mem_dout;
                m_owner = dma_req ? OWNER_DMA : STALL_OUT;
            end else if (m_owner == OWNER_DMA) begin
                m_dma_cycles++;
                if (!dma_req || m_dma_cycles == MAX_BURST) m_owner = STALL_OUT;
            end else begin
                m_cpu_cycles = 0;
                m_dma_cycles = 0;
                m_owner = OWNER_CPU;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("rst_cpu_rdy", cpu_rdy, 1);
            check("rst_dma_gnt", dma_gnt, 0);
            check("rst_dma_rvalid", dma_rvalid, 0);
        end else begin
            check("m_cpu_rdy", cpu_rdy, m_owner == OWNER_CPU);
            check("m_dma_gnt", dma_gnt, m_owner == OWNER_DMA);
            check("m_dma_rvalid", dma_rvalid, m_rvalid);
            if (m_rvalid) check("m_dma_rdata", dma_rdata, mem_dout);
            if (m_owner == OWNER_CPU) begin
                check("m_mem_addr_cpu", mem_addr, cpu_ab);
                check("m_mem_re_cpu", mem_re, cpu_re);
                check("m_mem_we_cpu", mem_we, cpu_we);
                if (cpu_we) check("m_mem_din_cpu", mem_din, cpu_do);
                check("m_cpu_di_pass", cpu_di, mem_dout);
            end else if (m_owner == OWNER_DMA) begin
                check("m_mem_addr_dma", mem_addr, dma_addr);
                check("m_mem_re_dma", mem_re, dma_re && !dma_we);
                check("m_mem_we_dma", mem_we, dma_we);
                if (dma_we) check("m_mem_din_dma", mem_din, dma_wdata);
                check("m_cpu_di_hold", cpu_di, m_latched);
            end else begin
                check("m_mem_re_idle", mem_re, 0);
                check("m_mem_we_idle", mem_we, 0);
                check("m_cpu_di_hold", cpu_di, m_latched);
            end
        end
    end

    initial begin
        int issued, received, cur_run, cur_gap;
        int runs[$];
        int gaps[$];

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h3000] = 8'h7E;
        mem[16'hBEEF] = 8'hEA;
        for (int i = 0; i < 40; i++) mem[16'h4000 + 16'(i)] = pat(i);

        repeat (2) @(posedge clk);
        #1;
        check("reset_cpu_rdy", cpu_rdy, 1);
        check("reset_dma_gnt", dma_gnt, 0);
        check("reset_cpu_di", cpu_di, 8'h00);
        reset = 1'b0;
        repeat (3) step();

        // Idle DMA: plain CPU read.
        cpu_ab = 16'h1234; cpu_re = 1'b1;
        #1;
        check("idle_mem_addr", mem_addr, 16'h1234);
        check("idle_mem_re", mem_re, 1);
        step();
        check("idle_cpu_di", cpu_di, 8'hA5);
        check("idle_cpu_rdy", cpu_rdy, 1);
        check("idle_dma_gnt", dma_gnt, 0);

        // Basic handoff during a CPU read, one DMA write.
        dma_req = 1'b1; dma_addr = 16'h2000; dma_wdata = 8'h55; dma_we = 1'b1;
        step();
        check("ho_cpu_rdy", cpu_rdy, 0);
        check("ho_dma_gnt", dma_gnt, 0);
        check("ho_mem_we", mem_we, 0);
        check("ho_mem_re", mem_re, 0);
        step();
        check("ho_gnt", dma_gnt, 1);
        check("ho_wr_we", mem_we, 1);
        check("ho_wr_addr", mem_addr, 16'h2000);
        check("ho_wr_din", mem_din, 8'h55);
        check("ho_cpu_di_hold", cpu_di, 8'hA5);
        dma_req = 1'b0;
        step();
        check("ret_gnt", dma_gnt, 0);
        check("ret_rdy", cpu_rdy, 0);
        dma_we = 1'b0;
        step();
        check("ret_cpu_rdy", cpu_rdy, 1);
        check("ret_reissue_addr", mem_addr, 16'h1234);
        step();
        check("ret_cpu_di", cpu_di, 8'hA5);
        check("ho_mem_2000", mem[16'h2000], 8'h55);

        // Write protection: no handoff while the CPU writes.
        cpu_re = 1'b0; cpu_we = 1'b1; dma_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_ab = 16'h1100 + 16'(k);
            cpu_do = 8'h11 * 8'(k + 1);
            step();
            check("wp_rdy_during_write", cpu_rdy, 1);
        end
        cpu_we = 1'b0;
        step();
        check("wp_handoff_after_write", cpu_rdy, 0);
        step();
        check("wp_gnt", dma_gnt, 1);
        dma_req = 1'b0;
        step();
        step();
        check("wp_mem_1100", mem[16'h1100], 8'h11);
        check("wp_mem_1101", mem[16'h1101], 8'h22);
        check("wp_mem_1102", mem[16'h1102], 8'h33);

        // Fairness: 40 reads with dma_req held.
        issued = 0; received = 0; cur_run = 0; cur_gap = 0;
        for (int cyc = 0; cyc < 400 && !(received == 40 && issued == 40 && !dma_gnt && cpu_rdy); cyc++) begin
            if (dma_rvalid) begin
                check("fair_rdata", dma_rdata, pat(received));
                received++;
            end
            if (dma_gnt) cur_run++;
            else if (cur_run > 0) begin
                runs.push_back(cur_run);
                cur_run = 0;
            end
            if (cpu_rdy) cur_gap++;
            if (dma_gnt && cur_gap > 0) begin
                if (runs.size() > 0) gaps.push_back(cur_gap);
                cur_gap = 0;
            end
            dma_req = (issued < 40);
            if (dma_gnt && issued < 40) begin
                dma_re = 1'b1;
                dma_addr = 16'h4000 + 16'(issued);
                issued++;
            end else begin
                dma_re = 1'b0;
            end
            step();
        end
        check("fair_received", received, 40);
        check("fair_runs", runs.size(), 3);
        if (runs.size() == 3) begin
            check("fair_run0", runs[0], 16);
            check("fair_run1", runs[1], 16);
            check("fair_run2", runs[2], 9);
        end
        check("fair_gaps", gaps.size(), 2);
        foreach (gaps[g]) check("fair_gap_ge2", gaps[g] >= 2, 1);

        // DMA read on the final granted cycle; dma_we beats dma_re.
        dma_req = 1'b1;
        for (int i = 0; i < 20 && !dma_gnt; i++) step();
        check("lat_gnt", dma_gnt, 1);
        dma_addr = 16'h3001; dma_wdata = 8'h99; dma_re = 1'b1; dma_we = 1'b1;
        #1;
        check("lat_we_wins_re", mem_re, 0);
        check("lat_we_wins_we", mem_we, 1);
        step();
        dma_addr = 16'h3000; dma_we = 1'b0; dma_req = 1'b0;
        #1;
        check("lat_rd_re", mem_re, 1);
        step();
        check("lat_rvalid", dma_rvalid, 1);
        check("lat_rdata", dma_rdata, 8'h7E);
        check("lat_ret_gnt", dma_gnt, 0);
        dma_re = 1'b0;
        step();
        check("lat_mem_3001", mem[16'h3001], 8'h99);

        // Reset in the middle of a burst.
        dma_req = 1'b1; dma_addr = 16'h5000;
        for (int i = 0; i < 20 && !dma_gnt; i++) step();
        check("rb_gnt", dma_gnt, 1);
        repeat (4) step();
        check("rb_gnt5", dma_gnt, 1);
        #2 reset = 1'b1;
        #1;
        check("rb_async_gnt", dma_gnt, 0);
        check("rb_async_rdy", cpu_rdy, 1);
        dma_req = 1'b0;
        step();
        reset = 1'b0;
        cpu_ab = 16'hBEEF; cpu_re = 1'b1;
        #1;
        check("rb_fetch_addr", mem_addr, 16'hBEEF);
        check("rb_fetch_re", mem_re, 1);
        step();
        check("rb_fetch_di", cpu_di, 8'hEA);
        check("rb_fetch_rdy", cpu_rdy, 1);
        cpu_re = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
